// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding, oversampling constants and the majority vote.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int OVERSAMPLE   = 16;
    localparam int DEFAULT_BAUD = 115200;
    localparam int MAJ_S0       = 7;
    localparam int MAJ_S1       = 8;
    localparam int MAJ_S2       = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops reset to RST_VAL so an idle-high line reads idle out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every FREQ_CLK/(16*baud) clocks.
// Shared between the receiver and transmitter; baud 0 selects the default rate.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned FREQ_CLK = 100000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_baud,
    input  logic        i_clear,
    input  logic        i_enable,
    output logic        o_tick
);

    logic [31:0] w_baud;
    logic [35:0] w_den;
    logic [35:0] w_quot;
    logic [35:0] w_div;
    logic [35:0] r_cnt;

    assign w_baud = (i_baud == 32'd0) ? 32'(DEFAULT_BAUD) : i_baud;
    assign w_den  = {w_baud, 4'b0000};
    assign w_quot = 36'(FREQ_CLK) / w_den;
    // Clamping to 1 keeps ticks flowing even for absurd baud values.
    assign w_div  = (w_quot == 36'd0) ? 36'd1 : w_quot;

    // >= rather than == so a mid-count baud change cannot strand the counter.
    assign o_tick = i_enable && (r_cnt >= (w_div - 36'd1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 36'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 3-sample majority per bit, one-entry holding
// register with valid/ack handshake, framing and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FREQ_CLK  = 100000000,
    parameter int          DATA_WDTH = 8
) (
    input  logic                 CLKip,
    input  logic                 RSTi,
    input  logic                 DATAi,
    input  logic [31:0]          BAUD_RATEi,
    input  logic                 RD_ACKi,
    output logic [DATA_WDTH-1:0] RXo,
    output logic                 VALIDo,
    output logic                 BUSYo,
    output logic                 FERRo,
    output logic                 OVRo
);

    localparam int IDX_W = (DATA_WDTH > 1) ? $clog2(DATA_WDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WDTH - 1);

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_decide;
    logic                 w_wrap;
    logic                 w_maj;
    rx_state_t            r_state;
    logic                 r_rx_d;
    logic [3:0]           r_s;
    logic [1:0]           r_smp;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_WDTH-1:0] r_shift;
    logic [DATA_WDTH-1:0] r_rx;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (CLKip),
        .i_rst (RSTi),
        .i_d   (DATAi),
        .o_q   (w_rx_s)
    );

    uart_baud_tick #(.FREQ_CLK(FREQ_CLK)) u_tick (
        .i_clk    (CLKip),
        .i_rst    (RSTi),
        .i_baud   (BAUD_RATEi),
        .i_clear  (r_state == IDLE),
        .i_enable (r_state != IDLE),
        .o_tick   (w_tick)
    );

    assign w_fall   = r_rx_d & ~w_rx_s;
    assign w_decide = w_tick && (r_s == 4'(MAJ_S2));
    assign w_wrap   = w_tick && (r_s == 4'(OVERSAMPLE - 1));
    // The third vote is the live synchronized sample on the s=9 tick.
    assign w_maj    = maj3(r_smp[0], r_smp[1], w_rx_s);

    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            r_state <= IDLE;
            r_rx_d  <= 1'b1;
            r_s     <= '0;
            r_smp   <= '0;
            r_idx   <= '0;
            r_rx    <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_rx_d <= w_rx_s;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (RD_ACKi && r_valid) begin
                r_valid <= 1'b0;
            end
            if (r_state == IDLE) begin
                r_s <= '0;
            end else if (w_tick) begin
                r_s <= (r_s == 4'(OVERSAMPLE - 1)) ? 4'd0 : r_s + 4'd1;
                if (r_s == 4'(MAJ_S0)) r_smp[0] <= w_rx_s;
                if (r_s == 4'(MAJ_S1)) r_smp[1] <= w_rx_s;
            end
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (w_fall) r_state <= START;
                end
                START: begin
                    if (w_decide && w_maj) begin
                        r_state <= IDLE;
                        r_s     <= '0;
                    end else if (w_wrap) begin
                        r_state <= DATA;
                        r_idx   <= '0;
                    end
                end
                DATA: begin
                    if (w_wrap) begin
                        if (r_idx == LAST_IDX) r_state <= STOP;
                        else                   r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                STOP: begin
                    // Decide at mid-stop and leave at once so the next start edge can resync.
                    if (w_decide) begin
                        if (w_maj) begin
                            r_rx    <= r_shift;
                            r_valid <= 1'b1;
                            r_ovr   <= r_valid && !RD_ACKi;
                        end else begin
                            r_ferr  <= 1'b1;
                        end
                        r_state <= IDLE;
                        r_s     <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKip) begin
        if ((r_state == DATA) && w_decide) begin
            r_shift[r_idx] <= w_maj;
        end
    end

    assign RXo    = r_rx;
    assign VALIDo = r_valid;
    assign BUSYo  = (r_state != IDLE);
    assign FERRo  = r_ferr;
    assign OVRo   = r_ovr;

endmodule
